// File: rtl/jtframe_joyscan_pkg.sv
// ============================================================================
// Module : jtframe_joyscan_pkg
// Brief  : Shared states and bit positions for the native joystick scanner.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package jtframe_joyscan_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        LOAD    = 3'd2,
        SHIFT   = 3'd3,
        PUBLISH = 3'd4
    } state_t;

    // Positions inside one player's byte of the chain (after inversion)
    localparam int unsigned C_CH_UP    = 7;
    localparam int unsigned C_CH_DOWN  = 6;
    localparam int unsigned C_CH_LEFT  = 5;
    localparam int unsigned C_CH_RIGHT = 4;
    localparam int unsigned C_CH_BTNX  = 3;
    localparam int unsigned C_CH_BTNY  = 2;

    // Positions inside the active-high player word
    localparam int unsigned C_JOY_RIGHT = 0;
    localparam int unsigned C_JOY_LEFT  = 1;
    localparam int unsigned C_JOY_DOWN  = 2;
    localparam int unsigned C_JOY_UP    = 3;
    localparam int unsigned C_JOY_A     = 4;
    localparam int unsigned C_JOY_B     = 5;
    localparam int unsigned C_JOY_C     = 6;
    localparam int unsigned C_JOY_START = 7;

endpackage

`default_nettype wire

// File: rtl/jtframe_joyscan_dec.sv
// ============================================================================
// Module : jtframe_joyscan_dec
// Brief  : Maps the select-high/select-low chain bytes onto one player word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module jtframe_joyscan_dec
    import jtframe_joyscan_pkg::*;
(
    input  logic [7:0] i_hi,
    input  logic [7:0] i_lo,
    output logic [7:0] o_joy
);

    // The select-low byte only contributes A and start; its other bits are don't-care.
    logic w_unused;
    assign w_unused = ^{i_hi[1:0], i_lo[7:4], i_lo[1:0]};

    always_comb begin
        o_joy              = '0;
        o_joy[C_JOY_RIGHT] = i_hi[C_CH_RIGHT];
        o_joy[C_JOY_LEFT]  = i_hi[C_CH_LEFT];
        o_joy[C_JOY_DOWN]  = i_hi[C_CH_DOWN];
        o_joy[C_JOY_UP]    = i_hi[C_CH_UP];
        o_joy[C_JOY_A]     = i_lo[C_CH_BTNX];
        o_joy[C_JOY_B]     = i_hi[C_CH_BTNX];
        o_joy[C_JOY_C]     = i_hi[C_CH_BTNY];
        o_joy[C_JOY_START] = i_lo[C_CH_BTNY];
    end

endmodule

`default_nettype wire

// File: rtl/jtframe_joyscan.sv
// ============================================================================
// Module : jtframe_joyscan
// Brief  : Drives a 74HC165 joystick chain twice per frame (select high/low).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module jtframe_joyscan
    import jtframe_joyscan_pkg::*;
#(
    parameter int CLKDIV      = 8,
    parameter int NBITS       = 16,
    parameter int SCAN_PERIOD = 1000,
    parameter int SEL_SETTLE  = 2
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       joy_data,
    output logic       joy_clk,
    output logic       joy_load,
    output logic       joy_select,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic       scan_done
);

    localparam int DIVW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int PERW = $clog2(SCAN_PERIOD + 1);
    localparam int SETW = (SEL_SETTLE > 1) ? $clog2(SEL_SETTLE) : 1;
    localparam int BITW = $clog2(NBITS + 1);
    localparam int HALF = NBITS / 2;

    logic [DIVW-1:0]  r_div;
    logic             w_tick;
    logic [1:0]       r_sync;
    logic             w_data;

    state_t           r_st;
    logic             r_phase;
    logic [PERW-1:0]  r_per;
    logic [SETW-1:0]  r_set;
    logic [BITW-1:0]  r_bit;
    logic [NBITS-1:0] r_sr;
    logic [NBITS-1:0] r_hi;
    logic [NBITS-1:0] r_lo;
    logic [7:0]       w_joy1;
    logic [7:0]       w_joy2;

    assign w_tick = (r_div == DIVW'(CLKDIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Idle level of the chain output is high (no button pressed).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], joy_data};
        end
    end

    assign w_data = r_sync[1];

    jtframe_joyscan_dec u_dec1 (
        .i_hi  (r_hi[NBITS-1 -: 8]),
        .i_lo  (r_lo[NBITS-1 -: 8]),
        .o_joy (w_joy1)
    );

    jtframe_joyscan_dec u_dec2 (
        .i_hi  (r_hi[HALF-1 -: 8]),
        .i_lo  (r_lo[HALF-1 -: 8]),
        .o_joy (w_joy2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st       <= IDLE;
            r_phase    <= 1'b1;
            r_per      <= '0;
            r_set      <= '0;
            r_bit      <= '0;
            r_sr       <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            joy_clk    <= 1'b0;
            joy_load   <= 1'b1;
            joy_select <= 1'b1;
            joy1       <= '0;
            joy2       <= '0;
            scan_done  <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            case (r_st)
                IDLE: begin
                    if (w_tick) begin
                        if (r_per != PERW'(SCAN_PERIOD)) begin
                            r_per <= r_per + 1'b1;
                        end
                        // Leave on the tick that reaches the period, or any later tick once enabled
                        if (r_per >= PERW'(SCAN_PERIOD - 1) && enable) begin
                            r_st       <= SETTLE;
                            r_phase    <= 1'b1;
                            r_set      <= '0;
                            joy_select <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (w_tick) begin
                        if (r_set == SETW'(SEL_SETTLE - 1)) begin
                            r_st     <= LOAD;
                            joy_load <= 1'b0;
                        end else begin
                            r_set <= r_set + 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (w_tick) begin
                        r_st     <= SHIFT;
                        joy_load <= 1'b1;
                        joy_clk  <= 1'b0;
                        r_bit    <= '0;
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        if (!joy_clk) begin
                            r_sr    <= {r_sr[NBITS-2:0], ~w_data};
                            joy_clk <= 1'b1;
                        end else begin
                            joy_clk <= 1'b0;
                            r_bit   <= r_bit + 1'b1;
                            if (r_bit == BITW'(NBITS - 1)) begin
                                if (r_phase) begin
                                    r_hi       <= r_sr;
                                    r_phase    <= 1'b0;
                                    r_set      <= '0;
                                    joy_select <= 1'b0;
                                    r_st       <= SETTLE;
                                end else begin
                                    r_lo       <= r_sr;
                                    joy_select <= 1'b1;
                                    r_st       <= PUBLISH;
                                end
                            end
                        end
                    end
                end
                PUBLISH: begin
                    joy1      <= w_joy1;
                    joy2      <= w_joy2;
                    scan_done <= 1'b1;
                    r_per     <= '0;
                    r_st      <= IDLE;
                end
                default: begin
                    r_st <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jtframe_joyscan.sv
// ============================================================================
// Module : tb_jtframe_joyscan
// Brief  : Self-checking bench with a 74HC165 chain model driving the scanner.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_jtframe_joyscan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       joy_data;
    logic       joy_clk;
    logic       joy_load;
    logic       joy_select;
    logic [7:0] joy1;
    logic [7:0] joy2;
    logic       scan_done;

    jtframe_joyscan #(
        .CLKDIV      (4),
        .NBITS       (16),
        .SCAN_PERIOD (10),
        .SEL_SETTLE  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .joy_data   (joy_data),
        .joy_clk    (joy_clk),
        .joy_load   (joy_load),
        .joy_select (joy_select),
        .joy1       (joy1),
        .joy2       (joy2),
        .scan_done  (scan_done)
    );

    always #5 clk = ~clk;

    // Chain model: parallel load while load is low, shift MSB-first on joy_clk rise
    logic [15:0] pat_hi = 16'hFFFF;
    logic [15:0] pat_lo = 16'hFFFF;
    logic [15:0] q = 16'hFFFF;
    logic        jclk_d = 1'b0;

    always @(posedge clk) begin
        jclk_d <= joy_clk;
        if (!joy_load) begin
            q <= joy_select ? pat_hi : pat_lo;
        end else if (joy_clk && !jclk_d) begin
            q <= {q[14:0], 1'b1};
        end
    end

    assign joy_data = q[15];

    int cyc = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int nclk = 0;
    always @(posedge joy_clk) nclk = nclk + 1;

    int         glitch = 0;
    logic [7:0] pj1 = 8'h00;
    logic [7:0] pj2 = 8'h00;
    always @(negedge clk) begin
        if (!rst && (joy1 != pj1 || joy2 != pj2) && !scan_done) glitch = glitch + 1;
        pj1 = joy1;
        pj2 = joy2;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic wait_done(input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (scan_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({name, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_load(input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (!joy_load) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({name, "_load_timeout"}, 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        logic [7:0]  j1;
        logic [7:0]  j2;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int base;
        int t;
        int nl;
        int nd;

        vecs[0] = '{16'hFFFF, 16'hFFFF, 8'h00, 8'h00};
        vecs[1] = '{16'h7FFF, 16'h7FFF, 8'h08, 8'h00};
        vecs[2] = '{16'hFFF7, 16'hFFF3, 8'h00, 8'hB0};
        vecs[3] = '{16'h03FF, 16'hFFFF, 8'h6F, 8'h00};
        vecs[4] = '{16'hFFFF, 16'hF3FF, 8'h90, 8'h00};
        vecs[5] = '{16'hEFBB, 16'hF7FB, 8'h11, 8'hC4};
        vecs[6] = '{16'hFCFC, 16'hFCFC, 8'h00, 8'h00};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outputs", {26'd0, joy_clk, joy_load, joy_select, scan_done, 2'b00},
            {26'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00});
        chk("rst_joy", {16'd0, joy1, joy2}, 32'd0);
        rst = 1'b0;
        base = nclk;

        // First scan timing
        wait_load("t1_l1");
        chk("t1_load1_cycle", cyc, 48);
        chk("t1_load1_select", {31'd0, joy_select}, 32'd1);
        for (int n = 0; n < 50 && !joy_load; n++) @(negedge clk);
        chk("t1_load1_release", cyc, 52);
        wait_load("t1_l2");
        chk("t1_load2_cycle", cyc, 188);
        chk("t1_load2_select", {31'd0, joy_select}, 32'd0);
        wait_done("t1");
        chk("t1_done_cycle", cyc, 321);
        chk("t1_clk_edges", nclk - base, 32);
        chk("t1_joy", {16'd0, joy1, joy2}, 32'd0);
        chk("t1_select_idle", {31'd0, joy_select}, 32'd1);
        @(negedge clk);
        chk("t1_done_pulse", {31'd0, scan_done}, 32'd0);

        // Table-driven decode vectors
        for (int i = 0; i < 7; i++) begin
            pat_hi = vecs[i].hi;
            pat_lo = vecs[i].lo;
            base = nclk;
            wait_done($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_joy1", i), {24'd0, joy1}, {24'd0, vecs[i].j1});
            chk($sformatf("vec%0d_joy2", i), {24'd0, joy2}, {24'd0, vecs[i].j2});
            chk($sformatf("vec%0d_clk_edges", i), nclk - base, 32);
        end

        // Pattern changes between the two loads of one scan
        pat_hi = 16'h7FFF;
        pat_lo = 16'hFFFF;
        wait_load("t6_l1");
        for (int n = 0; n < 50 && !joy_load; n++) @(negedge clk);
        pat_hi = 16'hFFFF;
        pat_lo = 16'hF7FF;
        wait_load("t6_l2");
        chk("t6_hold_joy1", {24'd0, joy1}, 32'h00);
        chk("t6_hold_joy2", {24'd0, joy2}, 32'h00);
        wait_done("t6");
        chk("t6_joy1", {24'd0, joy1}, 32'h18);
        chk("t6_joy2", {24'd0, joy2}, 32'h00);

        // enable dropped during phase-1 shifting
        pat_hi = 16'h7FFF;
        pat_lo = 16'h7FFF;
        wait_load("t4_l1");
        chk("t4_phase1", {31'd0, joy_select}, 32'd1);
        repeat (20) @(negedge clk);
        enable = 1'b0;
        wait_done("t4");
        chk("t4_joy1", {24'd0, joy1}, 32'h08);
        nl = 0;
        nd = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!joy_load) nl++;
            if (scan_done) nd++;
        end
        chk("t4_no_load", nl, 0);
        chk("t4_no_done", nd, 0);
        enable = 1'b1;
        t = 0;
        for (int n = 0; n < 100 && joy_load; n++) begin
            @(negedge clk);
            t++;
        end
        chk("t4_restart_latency", {31'd0, (t >= 9 && t <= 12)}, 32'd1);
        wait_done("t4b");
        chk("t4b_joy1", {24'd0, joy1}, 32'h08);

        // Asynchronous reset in the middle of a shift with joy_clk high
        wait_load("t5_l1");
        for (int n = 0; n < 200 && !joy_clk; n++) @(negedge clk);
        chk("t5_clk_high", {31'd0, joy_clk}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_clk", {31'd0, joy_clk}, 32'd0);
        chk("t5_async_load", {31'd0, joy_load}, 32'd1);
        chk("t5_async_joy1", {24'd0, joy1}, 32'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_done("t5");
        chk("t5_done_cycle", cyc, 321);
        chk("t5_joy1", {24'd0, joy1}, 32'h08);

        chk("no_partial_updates", glitch, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
